// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the key schedule.
// The S-box is computed (GF inverse + affine map) instead of tabulated.
package aes_pkg;

    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef logic [31:0] aes_word;

    typedef enum logic {
        KS_IDLE = 1'b0,
        KS_RUN  = 1'b1
    } key_sched_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Inverse as x^254 (zero maps to zero), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        if (x == 8'h00) inv = 8'h00;
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic aes_word rot_word(input aes_word w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic aes_word sub_word(input aes_word w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_key_expand_rnd.sv
// One AES-128 key expansion round: (key, rcon) -> next round key, purely combinational.
module aes_key_expand_rnd
    import aes_pkg::*;
(
    input  logic [127:0] key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    aes_word w0, w1, w2, w3;
    aes_word t;
    aes_word n0, n1, n2, n3;

    always_comb begin
        w0 = key[127:96];
        w1 = key[95:64];
        w2 = key[63:32];
        w3 = key[31:0];
        t  = sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key schedule: one round key per step pulse, feeding the round datapath.
//   state   | meaning
//   KS_IDLE | no schedule; key/rnd hold last values, waiting for start_i
//   KS_RUN  | round key rnd_o valid on rnd_key_o; step_i advances, abort_i abandons
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic             step_i,
    input  logic             abort_i,
    output logic [KEY_W-1:0] rnd_key_o,
    output logic [3:0]       rnd_o,
    output logic             key_vld_o,
    output logic             busy_o,
    output logic             done_o
);

    key_sched_state_t state_q, state_d;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] key_nxt;
    logic [3:0]       rnd_q;
    logic [7:0]       rcon_q;
    logic             done_q, done_d;
    logic             load, advance, clear;

    aes_key_expand_rnd u_expand (
        .key      (key_q),
        .rcon     (rcon_q),
        .next_key (key_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= KS_IDLE;
            key_q   <= '0;
            rnd_q   <= '0;
            rcon_q  <= RCON_INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                key_q  <= key_i;
                rnd_q  <= '0;
                rcon_q <= RCON_INIT;
            end else if (advance) begin
                key_q  <= key_nxt;
                rnd_q  <= rnd_q + 4'd1;
                rcon_q <= xtime(rcon_q);
            end else if (clear) begin
                rnd_q  <= '0;
                rcon_q <= RCON_INIT;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        clear   = 1'b0;
        case (state_q)
            KS_IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_d = KS_RUN;
                end
            end
            KS_RUN: begin
                // abort wins over a simultaneous step
                if (abort_i) begin
                    clear   = 1'b1;
                    state_d = KS_IDLE;
                end else if (step_i) begin
                    if (rnd_q < 4'(NR)) begin
                        advance = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = KS_IDLE;
                    end
                end
            end
            default: state_d = KS_IDLE;
        endcase
    end

    assign rnd_key_o = key_q;
    assign rnd_o     = rnd_q;
    assign key_vld_o = (state_q == KS_RUN);
    assign busy_o    = (state_q == KS_RUN);
    assign done_o    = done_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed + randomized bench for aes_key_sched against a word-level FIPS-197 key expansion model.
module tb_aes_key_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         step_i = 1'b0;
    logic         abort_i = 1'b0;
    logic [127:0] rnd_key_o;
    logic [3:0]   rnd_o;
    logic         key_vld_o;
    logic         busy_o;
    logic         done_o;

    int total = 0;
    int bad   = 0;

    // reference model state
    int           sb [256];
    logic [127:0] rk [11];
    bit           m_run;
    int           m_rnd;
    bit           m_done;
    bit           m_kk;
    logic [127:0] m_key;

    aes_key_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .key_i     (key_i),
        .step_i    (step_i),
        .abort_i   (abort_i),
        .rnd_key_o (rnd_key_o),
        .rnd_o     (rnd_o),
        .key_vld_o (key_vld_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // S-box from log/antilog tables over generator 3, then the bitwise affine map
    task automatic build_sbox();
        int alog [256];
        int lg [256];
        int c;
        alog[0] = 1;
        for (int i = 1; i < 256; i++) begin
            int a2;
            a2 = alog[i-1] << 1;
            if (a2 >= 256) a2 = a2 ^ 'h11b;
            alog[i] = alog[i-1] ^ a2;
        end
        for (int i = 0; i < 255; i++) lg[alog[i]] = i;
        c = 'h63;
        for (int x = 0; x < 256; x++) begin
            int inv;
            int s;
            inv = (x == 0) ? 0 : alog[(255 - lg[x]) % 255];
            s = 0;
            for (int b = 0; b < 8; b++) begin
                int bitv;
                bitv = ((inv >> b) ^ (inv >> ((b+4)%8)) ^ (inv >> ((b+5)%8))
                       ^ (inv >> ((b+6)%8)) ^ (inv >> ((b+7)%8)) ^ (c >> b)) & 1;
                s = s | (bitv << b);
            end
            sb[x] = s;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        int rc;
        rc = 1;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = (t << 8) | (t >> 24);
                t = {8'(sb[t[31:24]]), 8'(sb[t[23:16]]), 8'(sb[t[15:8]]), 8'(sb[t[7:0]])};
                t = t ^ (32'(rc) << 24);
                rc = rc * 2;
                if (rc >= 256) rc = rc ^ 'h11b;
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check_all(input string tag);
        if (m_kk) chk({tag, ".key"}, rnd_key_o, m_key);
        chk({tag, ".rnd"},  128'(rnd_o),     128'(m_rnd));
        chk({tag, ".vld"},  128'(key_vld_o), 128'(m_run));
        chk({tag, ".busy"}, 128'(busy_o),    128'(m_run));
        chk({tag, ".done"}, 128'(done_o),    128'(m_done));
    endtask

    // one clock with the given inputs, then the spec-level expectation
    task automatic cycle(input string tag, input bit st, input bit sp, input bit ab, input logic [127:0] k);
        start_i = st;
        step_i  = sp;
        abort_i = ab;
        key_i   = k;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        if (!m_run) begin
            if (st) begin
                expand(k);
                m_run = 1'b1;
                m_rnd = 0;
                m_key = rk[0];
                m_kk  = 1'b1;
            end
        end else if (ab) begin
            m_run = 1'b0;
            m_rnd = 0;
            m_kk  = 1'b0;
        end else if (sp) begin
            if (m_rnd < 10) begin
                m_rnd++;
                m_key = rk[m_rnd];
            end else begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end
        check_all(tag);
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_rnd = 0; m_done = 1'b0; m_kk = 1'b1; m_key = '0;
    endtask

    initial begin
        logic [127:0] ka, kb;
        int rc;
        build_sbox();

        // reset
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset");
        chk("reset.rcon", 128'(dut.rcon_q), 128'h01);

        // FIPS-197 key, start together with step (step ignored in idle)
        cycle("fips.start", 1, 1, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        for (int r = 1; r <= 10; r++) begin
            cycle("fips.step", 0, 1, 0, '0);
            if (r == 1)  chk("fips.rnd1",  rnd_key_o, 128'ha0fafe1788542cb123a339392a6c7605);
            if (r == 10) chk("fips.rnd10", rnd_key_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            repeat ($urandom_range(0, 2)) cycle("fips.gap", 0, 0, 0, '0);
        end
        cycle("fips.final", 0, 1, 0, '0);
        cycle("fips.after", 0, 0, 0, '0);

        // all-zero key with rcon sequence
        cycle("zero.start", 1, 0, 0, '0);
        rc = 1;
        for (int r = 0; r < 10; r++) begin
            chk("zero.rcon", 128'(dut.rcon_q), 128'(rc));
            rc = rc * 2;
            if (rc >= 256) rc = rc ^ 'h11b;
            cycle("zero.step", 0, 1, 0, '0);
            if (r == 0) chk("zero.rnd1", rnd_key_o, 128'h62636363626363636263636362636363);
        end
        cycle("zero.final", 0, 1, 0, '0);

        // start in the same cycle as done, then step held high
        ka = {$urandom, $urandom, $urandom, $urandom};
        cycle("hold.start_on_done", 1, 0, 0, ka);
        for (int r = 0; r < 11; r++) cycle("hold.step", 0, 1, 0, '0);
        repeat (3) cycle("hold.idle_step", 0, 1, 1, '0);

        // start at rnd 4 with another key is ignored
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        cycle("ign.start", 1, 0, 0, ka);
        repeat (4) cycle("ign.step", 0, 1, 0, '0);
        cycle("ign.restart", 1, 0, 0, kb);
        repeat (6) cycle("ign.step2", 0, 1, 0, '0);
        cycle("ign.final", 1, 1, 0, kb);
        cycle("ign.after", 0, 0, 0, '0);

        // abort with step at rnd 6
        ka = {$urandom, $urandom, $urandom, $urandom};
        cycle("abt.start", 1, 0, 0, ka);
        repeat (6) cycle("abt.step", 0, 1, 0, '0);
        cycle("abt.abort", 0, 1, 1, '0);
        repeat (3) cycle("abt.idle", 0, 1, 0, '0);
        kb = {$urandom, $urandom, $urandom, $urandom};
        cycle("abt.newstart", 1, 0, 0, kb);
        chk("abt.newkey", rnd_key_o, kb);

        // reset at rnd 3 with a coincident start
        repeat (3) cycle("rst.step", 0, 1, 0, '0);
        rst = 1'b1; start_i = 1'b1; step_i = 1'b0; key_i = ka;
        @(posedge clk);
        #1;
        rst = 1'b0; start_i = 1'b0;
        model_reset();
        check_all("rst.mid");
        chk("rst.rcon", 128'(dut.rcon_q), 128'h01);
        cycle("rst.idle", 0, 1, 0, '0);

        // randomized step/abort traffic
        for (int s = 0; s < 4; s++) begin
            ka = {$urandom, $urandom, $urandom, $urandom};
            cycle("rnd.start", 1, 0, 0, ka);
            for (int c = 0; c < 40 && m_run; c++)
                cycle("rnd.run", ($urandom % 4) == 0, ($urandom % 2) == 0,
                      ($urandom % 64) == 0, {$urandom, $urandom, $urandom, $urandom});
            repeat (2) cycle("rnd.drain", 0, 0, 0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
